rx_pdu_reader: RTL and testbench
================================

// Module: rx_pdu_reader
// PURPOSE
//  Drains the receiver's byte FIFO after an access-address match, parses the PDU (header, length, payload, 3-byte CRC),
//  writes payload bytes to a payload RAM port and reports length and CRC status. Sits directly downstream of the
//  receiver: consumes its FIFO read interface plus aa_found / crc_valid. Re-armed by the same start pulse as the receiver.
// PARAMETERS
//  MAX_LEN  37  largest accepted payload length in bytes; larger LEN is a length error
//  ADDR_W   6   payload RAM address width; 2**ADDR_W >= MAX_LEN
// PORTS
//  clk        in   1       system clock, all logic on rising edge
//  rst_n      in   1       asynchronous active-low reset
//  en         in   1       block enable; 0 freezes FSM and all outputs (no FIFO reads issued)
//  start      in   1       1-cycle pulse: abort any packet, clear status, go to WAIT_AA
//  aa_found   in   1       access address matched (level, from receiver)
//  fifo_empty in   1       receiver FIFO empty
//  fifo_rd_en out  1       FIFO pop request
//  fifo_data  in   8       FIFO read data, valid the cycle after fifo_rd_en
//  crc_valid  in   1       receiver CRC-residue-zero flag
//  hdr        out  8       captured PDU header byte
//  len        out  8       captured PDU length byte
//  pld_we     out  1       payload RAM write strobe
//  pld_addr   out  ADDR_W  payload RAM address (0 = first payload byte)
//  pld_data   out  8       payload RAM write data
//  busy       out  1       1 in WAIT_AA..CRC
//  done       out  1       packet finished (level, held until start)
//  crc_ok     out  1       crc_valid sampled at end of packet; valid when done=1
//  len_err    out  1       LEN > MAX_LEN; valid when done=1
// BEHAVIOUR
//  Reset: state=IDLE; fifo_rd_en, pld_we, busy, done, crc_ok, len_err = 0; hdr, len, pld_addr, pld_data = 0.
//  Clock and reset ports are clk and rst_n; one clock domain; reset is asynchronous, active-low.
//  FIFO handshake: fifo_rd_en is asserted for 1 cycle only when fifo_empty=0 in the same cycle; the byte is captured
//   from fifo_data on the next cycle (CAPTURE), during which fifo_rd_en=0. Throughput: 1 byte per 2 cycles.
//  FSM (advances only when en=1; start has priority over every transition, with or without en):
//   IDLE    : wait for start -> WAIT_AA.
//   WAIT_AA : aa_found=1 -> HDR.
//   HDR     : pop 1 byte -> hdr -> LEN.
//   LEN     : pop 1 byte -> len. If byte > MAX_LEN: len_err=1, crc_ok=0 -> DONE (no further pops).
//             If byte = 0 -> CRC. Else -> PLD with pld_addr=0.
//   PLD     : each captured byte: pld_we=1 for that cycle with pld_data=byte, pld_addr=index; index increments after
//             the write; after byte LEN-1 -> CRC. pld_addr never exceeds MAX_LEN-1.
//   CRC     : pop 3 bytes (discarded). On capture cycle of 3rd byte: crc_ok <= crc_valid -> DONE.
//   DONE    : done=1, busy=0; hold hdr/len/crc_ok/len_err until start. No FIFO reads.
//  start in any state: clears done, crc_ok, len_err, hdr, len, pld_addr; drops fifo_rd_en and pld_we that cycle;
//   a pop issued the previous cycle is discarded (receiver flushes its FIFO on the same start).
//  aa_found falling mid-packet is ignored; packet completes on byte count only.
//  fifo_empty=1 while a pop is due: stall with no read, no timeout.
//  en=0 during CAPTURE: capture is deferred; fifo_data is assumed stable while the FIFO is not popped.
//  rst_n low mid-packet: immediate return to reset values, IDLE (start required to re-arm).
// TESTING
//  1 start, aa_found, FIFO bytes {0x40,0x03,0xA1,0xB2,0xC3,c0,c1,c2}, crc_valid=1 -> 3 writes addr0..2 =A1,B2,C3;
//    hdr=0x40 len=3 done=1 crc_ok=1 len_err=0; exactly 8 fifo_rd_en pulses.
//  2 Same packet with crc_valid=0 at 3rd CRC byte -> done=1 crc_ok=0, payload still written.
//  3 LEN byte 0x30 (48 > 37) -> len_err=1 done=1 after 2 pops, no pld_we, no further fifo_rd_en.
//  4 LEN=0 -> no pld_we, 3 CRC pops, done after 5 total pops.
//  5 fifo_empty toggled 1 for 10 cycles between every byte -> no fifo_rd_en while empty; same result as test 1.
//  6 start pulse after 2nd payload byte, then a new packet {0x02,0x01,0x55,c0,c1,c2} -> done cleared, new packet
//    writes 0x55 to addr 0, len=1; also rst_n low mid-PLD -> all outputs 0, IDLE.

Source files
------------

// File: rtl/rx_pdu_reader.sv
// PDU reader: pops header, length, payload and three CRC bytes from the receiver FIFO,
// streams the payload into RAM and reports length and CRC status until the next start.
module rx_pdu_reader #(
  parameter int MAX_LEN = 37,
  parameter int ADDR_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              start,
  input  logic              aa_found,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic [7:0]        fifo_data,
  input  logic              crc_valid,
  output logic [7:0]        hdr,
  output logic [7:0]        len,
  output logic              pld_we,
  output logic [ADDR_W-1:0] pld_addr,
  output logic [7:0]        pld_data,
  output logic              busy,
  output logic              done,
  output logic              crc_ok,
  output logic              len_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_AA, S_HDR, S_LEN, S_PLD, S_CRC, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic              cap_q, cap_d;
  logic [7:0]        hdr_q, hdr_d;
  logic [7:0]        len_q, len_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              crc_ok_q, crc_ok_d;
  logic              len_err_q, len_err_d;
  logic              pop_state;

  always_comb begin
    state_d    = state_q;
    cap_d      = cap_q;
    hdr_d      = hdr_q;
    len_d      = len_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    crc_ok_d   = crc_ok_q;
    len_err_d  = len_err_q;
    fifo_rd_en = 1'b0;
    pld_we     = 1'b0;
    pld_data   = 8'h00;
    pop_state  = (state_q == S_HDR) || (state_q == S_LEN) ||
                 (state_q == S_PLD) || (state_q == S_CRC);

    if (start) begin
      state_d   = S_WAIT_AA;
      cap_d     = 1'b0;
      hdr_d     = 8'h00;
      len_d     = 8'h00;
      idx_d     = '0;
      cnt_d     = 2'd0;
      crc_ok_d  = 1'b0;
      len_err_d = 1'b0;
    end else if (en) begin
      if (state_q == S_WAIT_AA && aa_found) begin
        state_d = S_HDR;
      end else if (pop_state && !cap_q) begin
        // Issue phase: pop only when a byte is actually there.
        if (!fifo_empty) begin
          fifo_rd_en = 1'b1;
          cap_d      = 1'b1;
        end
      end else if (pop_state) begin
        cap_d = 1'b0;
        case (state_q)
          S_HDR: begin
            hdr_d   = fifo_data;
            state_d = S_LEN;
          end
          S_LEN: begin
            len_d = fifo_data;
            if (fifo_data > 8'(MAX_LEN)) begin
              len_err_d = 1'b1;
              crc_ok_d  = 1'b0;
              state_d   = S_DONE;
            end else if (fifo_data == 8'h00) begin
              cnt_d   = 2'd0;
              state_d = S_CRC;
            end else begin
              idx_d   = '0;
              state_d = S_PLD;
            end
          end
          S_PLD: begin
            pld_we   = 1'b1;
            pld_data = fifo_data;
            // Address stays on the last byte so it never runs past the buffer.
            if (8'(idx_q) == len_q - 8'd1) begin
              cnt_d   = 2'd0;
              state_d = S_CRC;
            end else begin
              idx_d = idx_q + ADDR_W'(1);
            end
          end
          S_CRC: begin
            if (cnt_q == 2'd2) begin
              crc_ok_d = crc_valid;
              state_d  = S_DONE;
            end else begin
              cnt_d = cnt_q + 2'd1;
            end
          end
          default: state_d = state_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cap_q     <= 1'b0;
      hdr_q     <= 8'h00;
      len_q     <= 8'h00;
      idx_q     <= '0;
      cnt_q     <= 2'd0;
      crc_ok_q  <= 1'b0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cap_q     <= cap_d;
      hdr_q     <= hdr_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      crc_ok_q  <= crc_ok_d;
      len_err_q <= len_err_d;
    end
  end

  assign hdr      = hdr_q;
  assign len      = len_q;
  assign pld_addr = idx_q;
  assign crc_ok   = crc_ok_q;
  assign len_err  = len_err_q;
  assign done     = (state_q == S_DONE);
  assign busy     = (state_q != S_IDLE) && (state_q != S_DONE);

endmodule

// File: tb/tb_rx_pdu_reader.sv
// Bench for rx_pdu_reader: a queue-backed FIFO feeds packets; expected writes, pop counts
// and status come from the packet contents and the length/CRC rules.
module tb_rx_pdu_reader;
  localparam int MAX_LEN = 37;
  localparam int ADDR_W  = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic en, start, aa_found, fifo_empty, crc_valid;
  logic [7:0] fifo_data;
  logic fifo_rd_en, pld_we, busy, done, crc_ok, len_err;
  logic [7:0] hdr, len, pld_data;
  logic [ADDR_W-1:0] pld_addr;

  rx_pdu_reader #(.MAX_LEN(MAX_LEN), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .start(start), .aa_found(aa_found),
    .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en), .fifo_data(fifo_data),
    .crc_valid(crc_valid), .hdr(hdr), .len(len), .pld_we(pld_we),
    .pld_addr(pld_addr), .pld_data(pld_data), .busy(busy), .done(done),
    .crc_ok(crc_ok), .len_err(len_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] q[$];
  logic [7:0] exp_pld[$];
  logic [7:0] pld_src[$];
  bit   prev_rd;
  int   stall_cnt;
  int   stall_mode;
  bit   en_rand;
  int   wr_cnt, pops;
  logic [7:0] last_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock: check outputs at the falling edge, then update the FIFO model after the rising edge.
  task automatic cycle();
    bit popped;
    @(negedge clk);
    if (fifo_rd_en === 1'b1) begin
      chk("rd_while_empty", {31'd0, fifo_empty}, 32'd0);
      chk("rd_back_to_back", {31'd0, prev_rd}, 32'd0);
      chk("rd_en_start_gate", {30'd0, en, start}, 32'd2);
      pops++;
    end
    if (pld_we === 1'b1) begin
      if (wr_cnt < exp_pld.size()) begin
        chk("pld_addr", 32'(pld_addr), wr_cnt);
        chk("pld_data", 32'(pld_data), 32'(exp_pld[wr_cnt]));
      end else begin
        chk("pld_extra_write", wr_cnt, exp_pld.size());
      end
      last_wdata = pld_data;
      wr_cnt++;
    end
    popped  = (fifo_rd_en === 1'b1);
    prev_rd = popped;
    @(posedge clk);
    #1;
    if (popped && q.size() > 0) fifo_data = q.pop_front();
    if (stall_cnt > 0) stall_cnt--;
    if (popped && stall_mode == 1) stall_cnt = 10;
    fifo_empty = (q.size() == 0) || (stall_cnt > 0) ||
                 (stall_mode == 2 && $urandom_range(0, 2) == 0);
    if (en_rand) en = ($urandom_range(0, 5) != 0);
  endtask

  task automatic run_pkt(input logic [7:0] h, input logic [7:0] l, input bit cv,
                         input int abort_at, output bit aborted);
    bit ok_len;
    aborted  = 1'b0;
    ok_len   = (l <= 8'(MAX_LEN));
    start    = 1'b1;
    aa_found = 1'b0;
    q.delete();
    cycle();
    start = 1'b0;
    wr_cnt = 0;
    pops = 0;
    prev_rd = 1'b0;
    stall_cnt = 0;
    exp_pld.delete();
    q.push_back(h);
    q.push_back(l);
    if (ok_len) begin
      for (int i = 0; i < int'(l); i++) begin
        q.push_back(pld_src[i]);
        exp_pld.push_back(pld_src[i]);
      end
      for (int i = 0; i < 3; i++) q.push_back(8'($urandom));
    end else begin
      for (int i = 0; i < 6; i++) q.push_back(8'($urandom));
    end
    crc_valid = cv;
    cycle();
    chk("clr_done", {31'd0, done}, 32'd0);
    chk("clr_hdr", 32'(hdr), 32'd0);
    chk("clr_len", 32'(len), 32'd0);
    chk("clr_status", {30'd0, crc_ok, len_err}, 32'd0);
    chk("clr_addr", 32'(pld_addr), 32'd0);
    chk("wait_busy", {31'd0, busy}, 32'd1);
    aa_found = 1'b1;
    for (int t = 0; t < 3000 && done !== 1'b1; t++) begin
      cycle();
      if (pops > 0) aa_found = 1'($urandom_range(0, 1));
      if (abort_at >= 0 && wr_cnt == abort_at) begin
        aborted = 1'b1;
        return;
      end
    end
    chk("done_reached", {31'd0, done}, 32'd1);
    repeat (6) cycle();
    chk("done_held", {31'd0, done}, 32'd1);
    chk("busy_in_done", {31'd0, busy}, 32'd0);
    chk("hdr", 32'(hdr), 32'(h));
    chk("len", 32'(len), 32'(l));
    chk("crc_ok", {31'd0, crc_ok}, {31'd0, cv & ok_len});
    chk("len_err", {31'd0, len_err}, {31'd0, ~ok_len});
    chk("write_count", wr_cnt, exp_pld.size());
    chk("pop_count", pops, ok_len ? int'(l) + 5 : 2);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, {26'd0, fifo_rd_en, pld_we, busy, done, crc_ok, len_err}, 32'd0);
    chk({tag, "_hdr_len"}, {16'd0, hdr, len}, 32'd0);
    chk({tag, "_pld"}, {18'd0, pld_addr, pld_data}, 32'd0);
  endtask

  initial begin
    bit ab;
    en = 1'b1; start = 1'b0; aa_found = 1'b0; fifo_empty = 1'b1;
    crc_valid = 1'b0; fifo_data = 8'h00; stall_mode = 0; en_rand = 1'b0;
    stall_cnt = 0; prev_rd = 1'b0; wr_cnt = 0; pops = 0; last_wdata = 8'h00;
    #1 rst_n = 1'b0;
    #11;
    chk_all_zero("reset");
    @(negedge clk) rst_n = 1'b1;
    aa_found = 1'b1;
    repeat (4) cycle();
    chk("idle_no_start_busy", {31'd0, busy}, 32'd0);
    chk("idle_no_pops", pops, 32'd0);

    // Basic packet, then the same with a failing CRC.
    pld_src.delete();
    pld_src.push_back(8'hA1); pld_src.push_back(8'hB2); pld_src.push_back(8'hC3);
    run_pkt(8'h40, 8'h03, 1'b1, -1, ab);
    chk("t1_pops_lit", pops, 32'd8);
    chk("t1_last_byte_lit", 32'(last_wdata), 32'hC3);
    chk("t1_crc_ok_lit", {31'd0, crc_ok}, 32'd1);
    run_pkt(8'h40, 8'h03, 1'b0, -1, ab);
    chk("t2_crc_bad_lit", {31'd0, crc_ok}, 32'd0);
    chk("t2_writes_lit", wr_cnt, 32'd3);

    // Oversized length and empty payload.
    run_pkt(8'h11, 8'h30, 1'b1, -1, ab);
    chk("t3_pops_lit", pops, 32'd2);
    chk("t3_len_err_lit", {31'd0, len_err}, 32'd1);
    run_pkt(8'h22, 8'h00, 1'b1, -1, ab);
    chk("t4_pops_lit", pops, 32'd5);

    // Long FIFO gaps between every byte.
    stall_mode = 1;
    run_pkt(8'h40, 8'h03, 1'b1, -1, ab);
    stall_mode = 0;

    // Restart after two payload bytes, then a short packet.
    pld_src.delete();
    for (int i = 0; i < 5; i++) pld_src.push_back(8'($urandom));
    run_pkt(8'h33, 8'h05, 1'b1, 2, ab);
    chk("t6_aborted", {31'd0, ab}, 32'd1);
    pld_src.delete();
    pld_src.push_back(8'h55);
    run_pkt(8'h02, 8'h01, 1'b1, -1, ab);
    chk("t6_last_byte_lit", 32'(last_wdata), 32'h55);

    // Asynchronous reset in the middle of the payload.
    pld_src.delete();
    for (int i = 0; i < 6; i++) pld_src.push_back(8'($urandom));
    run_pkt(8'h44, 8'h06, 1'b1, 2, ab);
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    @(negedge clk) rst_n = 1'b1;
    q.delete();
    pops = 0;
    aa_found = 1'b1;
    repeat (5) cycle();
    chk("midrst_idle_busy", {31'd0, busy}, 32'd0);
    chk("midrst_no_pops", pops, 32'd0);

    // Random packets with random stalls and enable gaps.
    stall_mode = 2;
    en_rand = 1'b1;
    for (int p = 0; p < 20; p++) begin
      logic [7:0] rl;
      rl = 8'($urandom_range(0, 40));
      if (p == 0) rl = 8'(MAX_LEN);
      if (p == 1) rl = 8'(MAX_LEN + 1);
      pld_src.delete();
      for (int i = 0; i < 40; i++) pld_src.push_back(8'($urandom));
      run_pkt(8'($urandom), rl, 1'($urandom_range(0, 1)), -1, ab);
    end
    en_rand = 1'b0;
    en = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
